unit_clause_sched: RTL and testbench
====================================

Name: unit_clause_sched

Overview:
Parametrised successor to the BCP unit-clause flag register. It holds the pending-unit-clause bitmap with the existing bulk load and keep-mask delete operations, plus single-bit set. A round-robin segmented scanner hands out one pending clause index at a time over a valid/ready handshake. It sits between clause evaluation (producers) and the BCP propagation engine (consumer).

Parameters:
CLAUSE_NUM, 64, number of clauses tracked (bitmap width)
SEG_W, 16, bits examined by the scanner per cycle; must divide CLAUSE_NUM
IDX_W, $clog2(CLAUSE_NUM), derived localparam; clause index width
NSEG, CLAUSE_NUM/SEG_W, derived localparam; segment count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
w_en  in  1  bulk load: bitmap <= wd
wd  in  CLAUSE_NUM  bulk load data
rw_en  in  1  keep-mask delete: bitmap <= bitmap & delete_unit
delete_unit  in  CLAUSE_NUM  keep mask; 0 bits clear
set_en  in  1  set one bitmap bit
set_idx  in  IDX_W  index for set_en
out_ready  in  1  consumer accepts out_idx
out_valid  out  1  out_idx holds a pending unit clause
out_idx  out  IDX_W  index of offered unit clause
unit_clause  out  CLAUSE_NUM  current bitmap (direct from register)
any_unit  out  1  OR-reduction of bitmap
unit_cnt  out  IDX_W+1  popcount of bitmap (combinational)
busy  out  1  scanner not IDLE

Behaviour:
- Reset (rst=0, async): bitmap 0, state IDLE, seg_ptr 0, out_idx 0, out_valid 0. Derived outputs are therefore also 0.
- pop = out_valid & out_ready.
- Bitmap next-state:
  - If w_en: bitmap <= wd. rw_en, set_en and pop clear are ignored that cycle.
  - Otherwise: bitmap <= ((bitmap & (rw_en ? delete_unit : all-ones)) & ~(pop ? onehot(out_idx) : 0)) | (set_en ? onehot(set_idx) : 0).
  - Set wins over delete and over pop on the same bit.
  - set_idx >= CLAUSE_NUM is ignored.
- unit_clause, any_unit and unit_cnt reflect the registered bitmap with zero added latency.
- Scanner FSM, states IDLE, SCAN, HOLD. It always inspects the registered bitmap.
  - IDLE: go to SCAN when any_unit=1. out_valid=0.
  - SCAN: examine segment seg_ptr.
    - If any bit is set: out_idx <= lowest set index in the segment, go to HOLD.
    - Else: seg_ptr <= (seg_ptr+1) mod NSEG, stay in SCAN.
    - If any_unit=0: go to IDLE, seg_ptr held.
  - HOLD: out_valid=1 (out_valid is registered, equal to state==HOLD).
    - On pop: bit cleared, seg_ptr unchanged, go to SCAN.
    - If bitmap[out_idx] is cleared without pop (rw_en mask, or set from another source): go to SCAN, out_valid=0 the next cycle.
- w_en in any state: seg_ptr <= 0, out_valid <= 0. Next state is SCAN if wd!=0, else IDLE.
- Latency: first out_valid arrives 1 cycle after entering SCAN when the hit is in the current segment. Worst case is NSEG cycles. After a pop, the next offer comes no sooner than 2 cycles later.
- Fairness: the scan resumes at the segment of the last pop. Lower bits of that segment re-set after the pop are found before higher segments. Wrap-around is from NSEG-1 to 0.
- out_idx is stable while out_valid=1 and no pop occurs.

Decomposition:
- Package sat_pkg: CLAUSE_NUM default, SEG_W default, typedef clause_vec_t (logic [CLAUSE_NUM-1:0]), typedef clause_idx_t, FSM state enum sched_state_e {IDLE, SCAN, HOLD}.
- One sub-module: seg_prio_enc, a combinational lowest-set-bit encoder of SEG_W bits. Outputs are hit and offset.
- Bitmap update, popcount and FSM stay in unit_clause_sched.

Test Plan:
- Reset mid-HOLD (out_idx=3, out_valid=1), drop rst -> out_valid, out_idx, unit_clause, unit_cnt and busy all 0 immediately, without waiting for clk.
- w_en, wd bits {3,20} -> 2 cycles later out_valid=1, out_idx=3. Pop -> bit3 cleared, unit_cnt=1; scan advances from seg0 to seg1 and offers out_idx=20.
- Wrap: bitmap {2,60}, seg_ptr=3 after popping 60 -> seg3 empty, seg_ptr wraps to 0, out_idx=2 offered.
- HOLD on idx 3, rw_en with delete_unit bit3=0 and out_ready=0 -> out_valid=0 next cycle. Bitmap {20} remains; 20 is offered later.
- Same cycle: set_en idx 7, rw_en clearing bit7 -> bitmap[7]=1. Next, w_en=1 with set_en idx 9 and wd=0 -> bitmap 0, busy 0 after one cycle.
- Pop every offer from a full bitmap (all 64 set) with out_ready=1 -> 64 distinct indices in ascending order. Finish with any_unit=0, unit_cnt=0, state IDLE.

Source files
------------

// File: rtl/sat_pkg.sv
// Shared types and defaults for the unit-clause scheduler.
package sat_pkg;

    localparam int CLAUSE_NUM_DFLT = 64;
    localparam int SEG_W_DFLT      = 16;

    typedef logic [CLAUSE_NUM_DFLT-1:0]         clause_vec_t;
    typedef logic [$clog2(CLAUSE_NUM_DFLT)-1:0] clause_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD
    } sched_state_e;

endpackage

// File: rtl/seg_prio_enc.sv
// Lowest-set-bit encoder over one scanner segment.
module seg_prio_enc #(
    parameter  int SEG_W = 16,
    localparam int OFF_W = (SEG_W > 1) ? $clog2(SEG_W) : 1
) (
    input  logic [SEG_W-1:0] seg,
    output logic             hit,
    output logic [OFF_W-1:0] offset
);

    always_comb begin
        hit    = |seg;
        offset = '0;
        // Walk downward so the lowest set bit is the last one written.
        for (int unsigned i = SEG_W; i > 0; i--) begin
            if (seg[i-1]) offset = OFF_W'(i - 1);
        end
    end

endmodule

// File: rtl/unit_clause_sched.sv
// Pending-unit-clause bitmap with a round-robin segmented scanner that
// offers one clause index at a time over valid/ready.
module unit_clause_sched
    import sat_pkg::*;
#(
    parameter  int CLAUSE_NUM = CLAUSE_NUM_DFLT,
    parameter  int SEG_W      = SEG_W_DFLT,
    localparam int IDX_W      = $clog2(CLAUSE_NUM),
    localparam int NSEG       = CLAUSE_NUM / SEG_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  w_en,
    input  logic [CLAUSE_NUM-1:0] wd,
    input  logic                  rw_en,
    input  logic [CLAUSE_NUM-1:0] delete_unit,
    input  logic                  set_en,
    input  logic [IDX_W-1:0]      set_idx,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [IDX_W-1:0]      out_idx,
    output logic [CLAUSE_NUM-1:0] unit_clause,
    output logic                  any_unit,
    output logic [IDX_W:0]        unit_cnt,
    output logic                  busy
);

    localparam int SEG_PTR_W = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int OFF_W     = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    logic [CLAUSE_NUM-1:0] bitmap_q, bitmap_d;
    sched_state_e          state_q, state_d;
    logic [SEG_PTR_W-1:0]  seg_ptr_q, seg_ptr_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;

    logic                  pop;
    logic [CLAUSE_NUM-1:0] keep_mask, pop_mask, set_mask;
    logic [SEG_W-1:0]      seg_bits;
    logic                  seg_hit;
    logic [OFF_W-1:0]      seg_off;

    assign out_valid   = (state_q == HOLD);
    assign out_idx     = out_idx_q;
    assign unit_clause = bitmap_q;
    assign any_unit    = |bitmap_q;
    assign busy        = (state_q != IDLE);
    assign pop         = out_valid & out_ready;

    always_comb begin
        unit_cnt = '0;
        for (int unsigned i = 0; i < CLAUSE_NUM; i++) begin
            unit_cnt = unit_cnt + (IDX_W+1)'(bitmap_q[i]);
        end
    end

    always_comb begin
        keep_mask = rw_en ? delete_unit : '1;
        pop_mask  = '0;
        set_mask  = '0;
        if (pop) pop_mask[out_idx_q] = 1'b1;
        if (set_en && ({1'b0, set_idx} < (IDX_W+1)'(CLAUSE_NUM))) set_mask[set_idx] = 1'b1;
        bitmap_d = w_en ? wd : (((bitmap_q & keep_mask) & ~pop_mask) | set_mask);
    end

    assign seg_bits = bitmap_q[int'(seg_ptr_q)*SEG_W +: SEG_W];

    seg_prio_enc #(.SEG_W(SEG_W)) u_enc (
        .seg    (seg_bits),
        .hit    (seg_hit),
        .offset (seg_off)
    );

    always_comb begin
        state_d   = state_q;
        seg_ptr_d = seg_ptr_q;
        out_idx_d = out_idx_q;
        unique case (state_q)
            IDLE: if (any_unit) state_d = SCAN;
            SCAN: begin
                if (!any_unit) begin
                    state_d = IDLE;
                end else if (seg_hit) begin
                    out_idx_d = IDX_W'(int'(seg_ptr_q)*SEG_W + int'(seg_off));
                    state_d   = HOLD;
                end else if (int'(seg_ptr_q) == NSEG - 1) begin
                    seg_ptr_d = '0;
                end else begin
                    seg_ptr_d = seg_ptr_q + 1'b1;
                end
            end
            HOLD: begin
                // Withdraw the offer in the same cycle its bit disappears.
                if (pop || !bitmap_d[out_idx_q]) state_d = SCAN;
            end
            default: state_d = IDLE;
        endcase
        if (w_en) begin
            seg_ptr_d = '0;
            state_d   = (wd != '0) ? SCAN : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bitmap_q  <= '0;
            state_q   <= IDLE;
            seg_ptr_q <= '0;
            out_idx_q <= '0;
        end else begin
            bitmap_q  <= bitmap_d;
            state_q   <= state_d;
            seg_ptr_q <= seg_ptr_d;
            out_idx_q <= out_idx_d;
        end
    end

endmodule

// File: tb/tb_unit_clause_sched.sv
// Self-checking bench for unit_clause_sched: directed scenarios plus
// randomized loads drained with random backpressure against a queue model.
module tb_unit_clause_sched;

    localparam int N = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic [N-1:0]  wd;
    logic          rw_en;
    logic [N-1:0]  delete_unit;
    logic          set_en;
    logic [5:0]    set_idx;
    logic          out_ready;
    logic          out_valid;
    logic [5:0]    out_idx;
    logic [N-1:0]  unit_clause;
    logic          any_unit;
    logic [6:0]    unit_cnt;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    unit_clause_sched #(.CLAUSE_NUM(64), .SEG_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .w_en        (w_en),
        .wd          (wd),
        .rw_en       (rw_en),
        .delete_unit (delete_unit),
        .set_en      (set_en),
        .set_idx     (set_idx),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .unit_clause (unit_clause),
        .any_unit    (any_unit),
        .unit_cnt    (unit_cnt),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        w_en = 0; wd = '0; rw_en = 0; delete_unit = '1;
        set_en = 0; set_idx = '0; out_ready = 0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic load(input logic [N-1:0] v);
        w_en = 1; wd = v;
        @(negedge clk);
        w_en = 0; wd = '0;
    endtask

    task automatic do_pop();
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    task automatic wait_valid(input int max_cyc, output bit seen);
        seen = 0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
    endtask

    task automatic test_reset();
        bit seen;
        reset_dut();
        n_checks++; if (out_valid !== 1'b0 || unit_clause !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_state valid=%b map=%h busy=%b want 0", out_valid, unit_clause, busy); end
        load(64'h8);
        wait_valid(8, seen);
        n_checks++; if (!seen || out_idx !== 6'd3) begin
            n_fail++; $display("FAIL reset_pre_hold seen=%b idx=%0d want 1/3", seen, out_idx); end
        #2 rst = 0;
        #1;
        n_checks++; if (out_valid !== 0 || out_idx !== 0 || unit_clause !== '0 || unit_cnt !== 0 || busy !== 0) begin
            n_fail++; $display("FAIL async_reset valid=%b idx=%0d map=%h cnt=%0d busy=%b want all 0",
                               out_valid, out_idx, unit_clause, unit_cnt, busy); end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_load_pop();
        bit seen;
        reset_dut();
        load((64'h1 << 3) | (64'h1 << 20));
        n_checks++; if (out_valid !== 0 || unit_cnt !== 7'd2 || any_unit !== 1) begin
            n_fail++; $display("FAIL load_first_cycle valid=%b cnt=%0d any=%b want 0/2/1", out_valid, unit_cnt, any_unit); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1 || out_idx !== 6'd3) begin
            n_fail++; $display("FAIL load_latency valid=%b idx=%0d want 1/3", out_valid, out_idx); end
        do_pop();
        n_checks++; if (unit_cnt !== 7'd1 || unit_clause !== (64'h1 << 20) || out_valid !== 0) begin
            n_fail++; $display("FAIL pop_clear cnt=%0d map=%h valid=%b want 1/%h/0", unit_cnt, unit_clause, out_valid, 64'h1 << 20); end
        wait_valid(8, seen);
        n_checks++; if (!seen || out_idx !== 6'd20) begin
            n_fail++; $display("FAIL seg_advance seen=%b idx=%0d want 1/20", seen, out_idx); end
        do_pop();
        @(negedge clk);
        n_checks++; if (busy !== 0 || any_unit !== 0) begin
            n_fail++; $display("FAIL drain_idle busy=%b any=%b want 0/0", busy, any_unit); end
    endtask

    task automatic test_wrap();
        bit seen;
        reset_dut();
        load(64'h1 << 60);
        wait_valid(10, seen);
        n_checks++; if (!seen || out_idx !== 6'd60) begin
            n_fail++; $display("FAIL wrap_first seen=%b idx=%0d want 1/60", seen, out_idx); end
        set_en = 1; set_idx = 6'd2;
        @(negedge clk);
        set_en = 0;
        n_checks++; if (unit_clause !== ((64'h1 << 60) | 64'h4) || out_valid !== 1 || out_idx !== 6'd60) begin
            n_fail++; $display("FAIL wrap_set_hold map=%h valid=%b idx=%0d want %h/1/60",
                               unit_clause, out_valid, out_idx, (64'h1 << 60) | 64'h4); end
        do_pop();
        wait_valid(6, seen);
        n_checks++; if (!seen || out_idx !== 6'd2) begin
            n_fail++; $display("FAIL wrap_around seen=%b idx=%0d want 1/2", seen, out_idx); end
        do_pop();
    endtask

    task automatic test_rw_drop();
        bit seen;
        reset_dut();
        load((64'h1 << 3) | (64'h1 << 20));
        wait_valid(8, seen);
        n_checks++; if (!seen || out_idx !== 6'd3) begin
            n_fail++; $display("FAIL drop_pre seen=%b idx=%0d want 1/3", seen, out_idx); end
        rw_en = 1; delete_unit = ~(64'h1 << 3); out_ready = 0;
        @(negedge clk);
        rw_en = 0; delete_unit = '1;
        n_checks++; if (out_valid !== 0 || unit_clause !== (64'h1 << 20)) begin
            n_fail++; $display("FAIL drop_withdraw valid=%b map=%h want 0/%h", out_valid, unit_clause, 64'h1 << 20); end
        wait_valid(8, seen);
        n_checks++; if (!seen || out_idx !== 6'd20) begin
            n_fail++; $display("FAIL drop_next seen=%b idx=%0d want 1/20", seen, out_idx); end
        do_pop();
    endtask

    task automatic test_set_vs_delete();
        reset_dut();
        set_en = 1; set_idx = 6'd7; rw_en = 1; delete_unit = ~(64'h1 << 7);
        @(negedge clk);
        set_en = 0; rw_en = 0; delete_unit = '1;
        n_checks++; if (unit_clause !== (64'h1 << 7)) begin
            n_fail++; $display("FAIL set_wins map=%h want %h", unit_clause, 64'h1 << 7); end
        w_en = 1; wd = '0; set_en = 1; set_idx = 6'd9;
        @(negedge clk);
        w_en = 0; set_en = 0;
        n_checks++; if (unit_clause !== '0 || busy !== 0 || out_valid !== 0) begin
            n_fail++; $display("FAIL load_wins map=%h busy=%b valid=%b want 0/0/0", unit_clause, busy, out_valid); end
    endtask

    task automatic test_full_sweep();
        int got;
        int bad_order;
        reset_dut();
        load('1);
        out_ready = 1;
        got = 0; bad_order = 0;
        for (int c = 0; c < 400 && got < N; c++) begin
            if (out_valid) begin
                if (out_idx !== 6'(got)) bad_order++;
                got++;
            end
            @(negedge clk);
        end
        out_ready = 0;
        n_checks++; if (got !== N || bad_order !== 0) begin
            n_fail++; $display("FAIL full_sweep pops=%0d misordered=%0d want %0d/0", got, bad_order, N); end
        @(negedge clk);
        n_checks++; if (any_unit !== 0 || unit_cnt !== 0 || busy !== 0) begin
            n_fail++; $display("FAIL sweep_end any=%b cnt=%0d busy=%b want 0/0/0", any_unit, unit_cnt, busy); end
    endtask

    // Only pops happen after the load, so offers must come in ascending index order.
    task automatic test_random();
        logic [N-1:0] model;
        int expq[$];
        bit hold_prev;
        logic [5:0] prev_idx;
        bit rdy;
        for (int it = 0; it < 6; it++) begin
            reset_dut();
            model = {$urandom, $urandom};
            if (it == 0) model = model & 64'h8000_0000_0000_0001;
            expq.delete();
            for (int b = 0; b < N; b++) if (model[b]) expq.push_back(b);
            load(model);
            hold_prev = 0; prev_idx = '0;
            for (int c = 0; c < 600 && (expq.size() > 0 || out_valid); c++) begin
                n_checks++; if (unit_clause !== model || unit_cnt !== 7'($countones(model)) || any_unit !== (model != '0)) begin
                    n_fail++; $display("FAIL rand_map it=%0d map=%h cnt=%0d any=%b want %h/%0d", it, unit_clause, unit_cnt, any_unit, model, $countones(model)); end
                if (hold_prev) begin
                    n_checks++; if (out_valid !== 1 || out_idx !== prev_idx) begin
                        n_fail++; $display("FAIL rand_stable it=%0d valid=%b idx=%0d want 1/%0d", it, out_valid, out_idx, prev_idx); end
                end
                rdy = 1'($urandom_range(0, 1));
                out_ready = rdy;
                if (out_valid && rdy) begin
                    n_checks++; if (expq.size() == 0 || out_idx !== 6'(expq[0])) begin
                        n_fail++; $display("FAIL rand_order it=%0d idx=%0d want %0d", it, out_idx, (expq.size() > 0) ? expq[0] : -1); end
                    if (expq.size() > 0) begin
                        model[expq[0]] = 1'b0;
                        void'(expq.pop_front());
                    end
                    hold_prev = 0;
                end else begin
                    hold_prev = out_valid;
                    prev_idx  = out_idx;
                end
                @(negedge clk);
            end
            out_ready = 0;
            n_checks++; if (expq.size() != 0) begin
                n_fail++; $display("FAIL rand_timeout it=%0d left=%0d want 0", it, expq.size()); end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #1;
        n_checks++; if (out_valid !== 0 || out_idx !== 0 || unit_cnt !== 0) begin
            n_fail++; $display("FAIL power_on_reset valid=%b idx=%0d cnt=%0d want 0", out_valid, out_idx, unit_cnt); end
        @(negedge clk);
        rst = 1;
        test_reset();
        test_load_pop();
        test_wrap();
        test_rw_drop();
        test_set_vs_delete();
        test_full_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
